// File: rtl/tm1640_pkg.sv
// TM1640 frame controller shared definitions: command opcodes, hex font, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tm1640_pkg;

    // TM1640 command opcodes (low bits are OR'ed in by the controller).
    localparam logic [7:0] TM_CMD_DATA = 8'h40;  // write data, auto-increment, normal mode
    localparam logic [7:0] TM_CMD_ADDR = 8'hC0;  // address set, grid address in [3:0]
    localparam logic [7:0] TM_CMD_CTRL = 8'h80;  // display control, on bit 3, brightness [2:0]

    // 7-segment font, gfedcba; entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] TM_FONT = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    // Encodings kept as plain constants so older code can still compare raw state bits.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_ACK       = 2'd2;
    localparam logic [1:0] ST_DONE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LOAD      = ST_LOAD,
        ACK       = ST_ACK,
        DONE_WAIT = ST_DONE_WAIT
    } tm_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to TM1640 segment byte, with decimal point and blanking.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (hex digit), dp (light seg bit 7), blank (force 0x00), seg (segment byte).
module seg7_hex_decode
    import tm1640_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = TM_FONT[nibble] | {dp, 7'b0};
        // Blanking wins over everything, including the decimal point.
        if (blank) begin
            seg = 8'h00;
        end
    end

endmodule

// File: rtl/tm1640_frame_ctrl.sv
// Sequences one full TM1640 frame (cmd1, cmd2, N digit bytes, cmd3) into the byte serializer.
// Latency: frame_busy/tm_latch with byte 0x40 one cycle after the start trigger.
// Backpressure: handshake on tm_busy; each byte held until busy seen high then low again.
// Ports: clk/rst (sync, active-high); digits/dp_mask/blank_mask/brightness/disp_on snapshot
//        inputs; update request; frame_busy status; tm_latch/tm_byte/tm_end to serializer,
//        tm_busy from serializer.
module tm1640_frame_ctrl
    import tm1640_pkg::*;
#(
    parameter int NUM_DIGITS     = 9,
    parameter int ADDR_BASE      = 0,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [2:0]              brightness,
    input  logic                    disp_on,
    input  logic                    update,
    output logic                    frame_busy,
    output logic                    tm_latch,
    output logic [7:0]              tm_byte,
    output logic                    tm_end,
    input  logic                    tm_busy
);

    localparam logic [4:0] LAST_IDX     = 5'(NUM_DIGITS + 2);  // Command3
    localparam logic [4:0] LAST_DIG_IDX = 5'(NUM_DIGITS + 1);  // final digit byte
    localparam int         RW           = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic [7:0] ADDR_CMD     = TM_CMD_ADDR | 8'(ADDR_BASE);

    tm_state_e state;
    logic [4:0] idx;
    logic       pending;
    logic       start_flag;
    logic [RW-1:0] refresh_cnt;

    // Frame snapshot; inputs may change freely once a frame has started.
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [2:0]              bright_q;
    logic                    on_q;

    logic       refresh_hit;
    logic       frame_start;
    logic [4:0] next_idx;
    logic [3:0] dig_nib;
    logic       dig_dp;
    logic       dig_blank;
    logic [7:0] seg_byte;
    logic [7:0] next_byte;
    logic       next_end;

    assign refresh_hit = (REFRESH_CYCLES > 0) && (refresh_cnt == REFRESH_LAST);
    assign frame_start = (state == IDLE) && (update || pending || start_flag || refresh_hit);
    assign next_idx    = idx + 5'd1;

    // Latch is offered in LOAD only while the serializer is free, then held through ACK
    // until the serializer shows it has taken the byte.
    assign tm_latch = (state == ACK) || ((state == LOAD) && !tm_busy);

    // Single decoder shared by all digits, steered by the byte about to be loaded.
    always_comb begin
        dig_nib   = 4'h0;
        dig_dp    = 1'b0;
        dig_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (next_idx == 5'(i + 2)) begin
                dig_nib   = digits_q[4*i +: 4];
                dig_dp    = dp_q[i];
                dig_blank = blank_q[i];
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble (dig_nib),
        .dp     (dig_dp),
        .blank  (dig_blank),
        .seg    (seg_byte)
    );

    // Byte 0 is loaded directly at frame start, so only indices 1..LAST appear here.
    always_comb begin
        next_byte = seg_byte;
        next_end  = (next_idx == LAST_DIG_IDX);
        if (next_idx == 5'd1) begin
            next_byte = ADDR_CMD;
            next_end  = 1'b0;
        end else if (next_idx == LAST_IDX) begin
            next_byte = TM_CMD_CTRL | {4'b0000, on_q, bright_q};
            next_end  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 5'd0;
            pending     <= 1'b0;
            start_flag  <= 1'b1;
            refresh_cnt <= '0;
            frame_busy  <= 1'b0;
            tm_byte     <= 8'h00;
            tm_end      <= 1'b0;
            digits_q    <= '0;
            dp_q        <= '0;
            blank_q     <= '0;
            bright_q    <= 3'd0;
            on_q        <= 1'b0;
        end else begin
            // Requests during a frame collapse into a single follow-up frame.
            if (update && (state != IDLE)) begin
                pending <= 1'b1;
            end

            if (frame_start) begin
                refresh_cnt <= '0;
            end else if ((state == IDLE) && (REFRESH_CYCLES > 0)) begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        digits_q   <= digits;
                        dp_q       <= dp_mask;
                        blank_q    <= blank_mask;
                        bright_q   <= brightness;
                        on_q       <= disp_on;
                        idx        <= 5'd0;
                        tm_byte    <= TM_CMD_DATA;
                        tm_end     <= 1'b1;
                        frame_busy <= 1'b1;
                        pending    <= 1'b0;
                        start_flag <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (!tm_busy) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (tm_busy) begin
                        state <= DONE_WAIT;
                    end
                end
                DONE_WAIT: begin
                    if (!tm_busy) begin
                        if (idx == LAST_IDX) begin
                            frame_busy <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx     <= next_idx;
                            tm_byte <= next_byte;
                            tm_end  <= next_end;
                            state   <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1640_frame_ctrl.sv
// Bench for tm1640_frame_ctrl: two instances (9-digit default, 4-digit with refresh),
// each with a behavioural serializer whose accepted bytes are scored against a queue.
// Stimulus drives 1 ns after posedge; the serializer models act on negedge.
module tb_tm1640_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance A: defaults (9 digits, base 0, no refresh)
    logic        rst_a = 1'b1;
    logic [35:0] digits_a = '0;
    logic [8:0]  dp_a = '0, blank_a = '0;
    logic [2:0]  bright_a = '0;
    logic        on_a = 1'b0, update_a = 1'b0;
    logic        frame_busy_a, tm_latch_a, tm_end_a;
    logic [7:0]  tm_byte_a;
    logic        tm_busy_a = 1'b0;

    // Instance B: 4 digits at grid 12, refresh every 1000 idle cycles
    logic        rst_b = 1'b1;
    logic [15:0] digits_b = 16'hFA50;
    logic [3:0]  dp_b = 4'b0100, blank_b = 4'b0000;
    logic [2:0]  bright_b = 3'd2;
    logic        on_b = 1'b0, update_b = 1'b0;
    logic        frame_busy_b, tm_latch_b, tm_end_b;
    logic [7:0]  tm_byte_b;
    logic        tm_busy_b = 1'b0;

    tm1640_frame_ctrl u_dut_a (
        .clk(clk), .rst(rst_a), .digits(digits_a), .dp_mask(dp_a), .blank_mask(blank_a),
        .brightness(bright_a), .disp_on(on_a), .update(update_a), .frame_busy(frame_busy_a),
        .tm_latch(tm_latch_a), .tm_byte(tm_byte_a), .tm_end(tm_end_a), .tm_busy(tm_busy_a)
    );

    tm1640_frame_ctrl #(.NUM_DIGITS(4), .ADDR_BASE(12), .REFRESH_CYCLES(1000)) u_dut_b (
        .clk(clk), .rst(rst_b), .digits(digits_b), .dp_mask(dp_b), .blank_mask(blank_b),
        .brightness(bright_b), .disp_on(on_b), .update(update_b), .frame_busy(frame_busy_b),
        .tm_latch(tm_latch_b), .tm_byte(tm_byte_b), .tm_end(tm_end_b), .tm_busy(tm_busy_b)
    );

    // Expected serializer traffic, {end, byte}
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] vec [12];
    int caps_a = 0, caps_b = 0;
    bit alt_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 8'h3F; 4'h1: font = 8'h06; 4'h2: font = 8'h5B; 4'h3: font = 8'h4F;
            4'h4: font = 8'h66; 4'h5: font = 8'h6D; 4'h6: font = 8'h7D; 4'h7: font = 8'h07;
            4'h8: font = 8'h7F; 4'h9: font = 8'h6F; 4'hA: font = 8'h77; 4'hB: font = 8'h7C;
            4'hC: font = 8'h39; 4'hD: font = 8'h5E; 4'hE: font = 8'h79; default: font = 8'h71;
        endcase
    endfunction

    task automatic push_frame_a(input logic [35:0] dg, input logic [8:0] dp, input logic [8:0] bl,
                                input logic [2:0] br, input logic on, input int nbytes);
        logic [8:0] f [12];
        logic [7:0] s;
        f[0] = 9'h140;
        f[1] = 9'h0C0;
        for (int i = 0; i < 9; i++) begin
            s = bl[i] ? 8'h00 : (font(dg[4*i +: 4]) | (dp[i] ? 8'h80 : 8'h00));
            f[2+i] = {(i == 8), s};
        end
        f[11] = {1'b1, 4'b1000, on, br};
        for (int i = 0; i < nbytes; i++) exp_a.push_back(f[i]);
    endtask

    // Serializer model A: accepts on latch, raises busy next cycle for 3 cycles.
    int  cnt_a = 0;
    bit  took_a = 1'b0;
    logic [8:0] e_a;
    always @(negedge clk) begin
        if (rst_a) begin
            tm_busy_a = 1'b0; took_a = 1'b0; cnt_a = 0;
        end else if (tm_busy_a) begin
            if (cnt_a <= 1) begin tm_busy_a = 1'b0; took_a = 1'b0; end
            else cnt_a--;
        end else if (took_a) begin
            tm_busy_a = 1'b1; cnt_a = 3;
        end else if (tm_latch_a) begin
            took_a = 1'b1;
            caps_a++;
            if (exp_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_byte_a: got 0x%0h, expected none", {tm_end_a, tm_byte_a});
            end else begin
                e_a = exp_a.pop_front();
                check($sformatf("byte_a#%0d", caps_a), {23'd0, tm_end_a, tm_byte_a}, {23'd0, e_a});
            end
        end
    end

    // Serializer model B: same handshake, with a 500-cycle stall on one byte of frame 2.
    int  cnt_b = 0;
    bit  took_b = 1'b0, stall_act = 1'b0, stall_bad = 1'b0;
    logic [7:0] stall_byte;
    logic [8:0] e_b;
    always @(negedge clk) begin
        if (rst_b) begin
            tm_busy_b = 1'b0; took_b = 1'b0; cnt_b = 0; stall_act = 1'b0;
        end else if (tm_busy_b) begin
            if (stall_act && (tm_latch_b || tm_byte_b != stall_byte)) stall_bad = 1'b1;
            if (cnt_b <= 1) begin
                tm_busy_b = 1'b0; took_b = 1'b0;
                if (stall_act) begin
                    check("stall_stable", {31'd0, stall_bad}, 32'd0);
                    stall_act = 1'b0;
                end
            end else cnt_b--;
        end else if (took_b) begin
            tm_busy_b = 1'b1;
            cnt_b = (caps_b == 12) ? 500 : 3;
            if (caps_b == 12) begin
                stall_act = 1'b1; stall_bad = 1'b0; stall_byte = tm_byte_b;
            end
        end else if (tm_latch_b) begin
            took_b = 1'b1;
            caps_b++;
            if (exp_b.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_byte_b: got 0x%0h, expected none", {tm_end_b, tm_byte_b});
            end else begin
                e_b = exp_b.pop_front();
                check($sformatf("byte_b#%0d", caps_b), {23'd0, tm_end_b, tm_byte_b}, {23'd0, e_b});
            end
        end
    end

    // Refresh spacing on B: idle cycles between consecutive frame starts.
    int idle_b = 0, starts_b = 0;
    bit prev_fb_b = 1'b0;
    always @(negedge clk) begin
        if (rst_b) begin
            idle_b = 0; starts_b = 0; prev_fb_b = 1'b0;
        end else begin
            if (frame_busy_b && !prev_fb_b) begin
                if (starts_b > 0) check("refresh_gap", idle_b, 32'd1000);
                starts_b++;
                idle_b = 0;
            end else if (!frame_busy_b) begin
                idle_b++;
            end
            prev_fb_b = frame_busy_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        while (frame_busy_a && n < budget) begin tick(); n++; end
        if (frame_busy_a) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout_idle_a: frame_busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    task automatic wait_caps_a(input int target, input int budget);
        int n = 0;
        while (caps_a < target && n < budget) begin tick(); n++; end
        if (caps_a < target) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout_caps_a: got %0d bytes, expected %0d", caps_a, target);
        end
    endtask

    task automatic pulse_update_a();
        update_a = 1'b1;
        tick();
        update_a = 1'b0;
    endtask

    task automatic check_start_a(input string name);
        check({name, "_busy"},  {31'd0, frame_busy_a}, 32'd1);
        check({name, "_latch"}, {31'd0, tm_latch_a},   32'd1);
        check({name, "_byte"},  {24'd0, tm_byte_a},    32'h40);
        check({name, "_end"},   {31'd0, tm_end_a},     32'd1);
    endtask

    task automatic check_reset_a(input string name);
        check({name, "_latch"}, {31'd0, tm_latch_a},   32'd0);
        check({name, "_byte"},  {24'd0, tm_byte_a},    32'h00);
        check({name, "_end"},   {31'd0, tm_end_a},     32'd0);
        check({name, "_busy"},  {31'd0, frame_busy_a}, 32'd0);
    endtask

    // Instance B sequence: three frames (auto-start + two refreshes), then parked in reset.
    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            exp_b.push_back(9'h140); exp_b.push_back(9'h0CC); exp_b.push_back(9'h03F);
            exp_b.push_back(9'h06D); exp_b.push_back(9'h0F7); exp_b.push_back(9'h171);
            exp_b.push_back(9'h182);
        end
        repeat (3) tick();
        rst_b = 1'b0;
        n = 0;
        while (!(caps_b >= 21 && !frame_busy_b) && n < 8000) begin tick(); n++; end
        if (caps_b < 21 || frame_busy_b) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout_b: got %0d bytes, expected 21", caps_b);
        end
        rst_b = 1'b1;
        alt_done = 1'b1;
    end

    // Instance A sequence
    initial begin
        int base, n;
        repeat (3) tick();
        check_reset_a("reset");

        // Reset start: digits 1..9, brightness 7, display on
        digits_a = 36'h987654321; bright_a = 3'd7; on_a = 1'b1;
        vec = '{9'h140, 9'h0C0, 9'h006, 9'h05B, 9'h04F, 9'h066,
                9'h06D, 9'h07D, 9'h007, 9'h07F, 9'h16F, 9'h18F};
        for (int i = 0; i < 12; i++) exp_a.push_back(vec[i]);
        rst_a = 1'b0;
        tick();
        check_start_a("auto_start");
        wait_idle_a(400);

        // Masks: dp on digit 0, blank on digit 8
        digits_a = 36'h888888888; dp_a = 9'h001; blank_a = 9'h100;
        vec = '{9'h140, 9'h0C0, 9'h0FF, 9'h07F, 9'h07F, 9'h07F,
                9'h07F, 9'h07F, 9'h07F, 9'h07F, 9'h100, 9'h18F};
        for (int i = 0; i < 12; i++) exp_a.push_back(vec[i]);
        pulse_update_a();
        check_start_a("update_start");
        wait_idle_a(400);

        // Coalescing: three mid-frame requests yield one frame with inputs at its start
        digits_a = 36'h13579BDF0; dp_a = 9'h000; blank_a = 9'h000; bright_a = 3'd3;
        push_frame_a(36'h13579BDF0, 9'h000, 9'h000, 3'd3, 1'b1, 12);
        base = caps_a;
        pulse_update_a();
        wait_caps_a(base + 3, 200);
        digits_a = 36'h000000000; bright_a = 3'd5;
        push_frame_a(36'h2468ACE13, 9'h155, 9'h022, 3'd1, 1'b1, 12);
        pulse_update_a();
        repeat (4) tick();
        pulse_update_a();
        repeat (6) tick();
        pulse_update_a();
        digits_a = 36'h2468ACE13; dp_a = 9'h155; blank_a = 9'h022; bright_a = 3'd1;
        wait_idle_a(400);
        tick();
        check("coalesce_start", {31'd0, frame_busy_a}, 32'd1);
        wait_idle_a(400);
        base = caps_a;
        repeat (150) tick();
        check("no_extra_busy", {31'd0, frame_busy_a}, 32'd0);
        check("no_extra_bytes", caps_a, base);

        // Update in the return-to-idle cycle restarts immediately
        digits_a = 36'h0FEDCBA98; dp_a = 9'h000; blank_a = 9'h000; bright_a = 3'd6; on_a = 1'b0;
        push_frame_a(36'h0FEDCBA98, 9'h000, 9'h000, 3'd6, 1'b0, 12);
        pulse_update_a();
        wait_idle_a(400);
        digits_a = 36'h111111111; bright_a = 3'd0; on_a = 1'b1;
        push_frame_a(36'h111111111, 9'h000, 9'h000, 3'd0, 1'b1, 12);
        pulse_update_a();
        check_start_a("restart");
        wait_idle_a(400);

        // Reset during data byte 4, then automatic full frame
        digits_a = 36'h987654321; bright_a = 3'd7; on_a = 1'b1;
        push_frame_a(36'h987654321, 9'h000, 9'h000, 3'd7, 1'b1, 7);
        base = caps_a;
        pulse_update_a();
        wait_caps_a(base + 7, 200);
        rst_a = 1'b1;
        push_frame_a(36'h987654321, 9'h000, 9'h000, 3'd7, 1'b1, 12);
        tick();
        check_reset_a("midrst");
        rst_a = 1'b0;
        tick();
        check_start_a("rst_restart");
        wait_idle_a(400);

        n = 0;
        while (!alt_done && n < 8000) begin tick(); n++; end
        if (!alt_done) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout_alt: instance B not done, expected done");
        end
        check("queue_a_empty", exp_a.size(), 32'd0);
        check("queue_b_empty", exp_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1640_frame_ctrl.md
# tm1640_frame_ctrl

- Parametrised frame sequencer for TM1640-driven 7-segment displays; replaces hand-written per-design instruction lists.
- Snapshots a packed hex-digit vector, decimal-point and blank masks, and brightness, then emits one complete TM1640 frame: Command1, Command2, N data bytes, Command3.
- Sits between application logic and the existing byte-level `tm1640` serializer, driving its `latch`/`byte`/`end` inputs and watching its `busy` output.
- Supports runtime brightness, automatic update after reset, optional periodic refresh, and coalesces update requests that arrive during a frame.

## Interface
- `NUM_DIGITS`, default 9: digit count, legal range 1..16.
- `ADDR_BASE`, default 0: TM1640 grid address of digit 0; `ADDR_BASE + NUM_DIGITS` must be ≤ 16.
- `REFRESH_CYCLES`, default 0: self-triggered frame period in clk cycles; 0 disables it.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `digits  in  4*NUM_DIGITS`: hex nibbles; digit i is `[4i+3:4i]`; digit 0 is leftmost.
- `dp_mask  in  NUM_DIGITS`: 1 lights the decimal point (seg bit 7) of digit i.
- `blank_mask  in  NUM_DIGITS`: 1 forces data byte 0x00 for digit i (the dp bit is also cleared).
- `brightness  in  3`: Command3 brightness bits [2:0].
- `disp_on  in  1`: Command3 bit 3.
- `update  in  1`: single-cycle request to send a frame.
- `frame_busy  out  1`: high from frame start until the final byte completes.
- `tm_latch  out  1`: byte-valid toward the serializer.
- `tm_byte  out  8`: byte toward the serializer.
- `tm_end  out  1`: stop condition after this byte.
- `tm_busy  in  1`: serializer busy.

## Operation
- Frame byte order is fixed; a frame is NUM_DIGITS+3 bytes:
  - 0x40 with end=1 (write data, auto-increment, normal mode).
  - `0xC0 | ADDR_BASE` with end=0.
  - Digit 0..N-1 segment bytes; the last one has end=1, the others end=0.
  - `{4'b1000, disp_on, brightness}` with end=1.
- Font (gfedcba) for 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. The dp bit ORs in 0x80.
- Snapshot: `digits`, `dp_mask`, `blank_mask`, `brightness` and `disp_on` are registered in the cycle a frame starts. Input changes during a frame affect only the next frame.
- Frame start occurs when IDLE and any of the following is true:
  - `update` is high;
  - `pending` is set;
  - the post-reset start flag is set;
  - the refresh counter expires.
- `pending` is set by `update` arriving while not IDLE. Multiple such updates coalesce into one. `pending` clears at frame start.
- FSM states:
  - IDLE: waiting for a frame start.
  - LOAD: drive `tm_byte`/`tm_end` and assert `tm_latch`.
  - ACK: hold `tm_latch` until `tm_busy`=1, then deassert `tm_latch`.
  - DONE_WAIT: wait for `tm_busy`=0. Then go to LOAD if bytes remain, else to IDLE.
- Byte index counter: 5 bits, 0..NUM_DIGITS+2. Wrap-around is not permitted.
- Refresh counter:
  - Counts only in IDLE and reloads at every frame start.
  - When it expires it behaves exactly like `update`.
- A frame in progress is never aborted except by `rst`.

## Timing
- Reset values:
  - `tm_latch`=0, `tm_byte`=0x00, `tm_end`=0, `frame_busy`=0.
  - State IDLE, `pending`=0, start flag=1.
  - The first frame therefore starts on the 2nd cycle after `rst` drops.
- Start latency: `update` at cycle t causes `frame_busy` = 1 and `tm_latch` = 1 with byte 0x40 at t+1.
- Each byte is held stable while `tm_latch`=1.
- `tm_latch` falls the cycle after `tm_busy` is sampled high.
- The next `tm_latch` rises no earlier than 1 cycle after `tm_busy` is sampled low.
- `frame_busy` falls in the cycle the FSM returns to IDLE.
- `update` in that same cycle starts a new frame immediately on the next cycle (no `pending` needed).
- `rst` mid-frame: all outputs return to reset values on the next edge. The serializer is reset from the same `rst`; afterwards a full frame restarts automatically.
- If `tm_busy` is already high on entry to LOAD, the block stays in LOAD with `tm_latch`=0 until it goes low.

## Structure
- Package `tm1640_pkg` holds:
  - `TM_CMD_DATA` = 8'h40, `TM_CMD_ADDR` = 8'hC0, `TM_CMD_CTRL` = 8'h80;
  - the 16-entry font constant;
  - the FSM state enum.
- Sub-module `seg7_hex_decode` (combinational): inputs nibble, dp, blank; output byte. Instantiated once and muxed by byte index.
- Serializer `tm1640` is not instantiated inside this block; the top level connects the two.

## Test plan
- **Reset start.** Release `rst` with `NUM_DIGITS`=9 and digits 1..9, `brightness`=7, `disp_on`=1, using a `tm1640` model. Expect bytes 40, C0, 06 5B 4F 66 6D 7D 07 7F 6F, 8F; end flags 1, 0, 0×8 then 1, 1.
- **Masks.** Set `dp_mask`=0x001 and `blank_mask`=0x100 on digits 8,8,…,8. Expect data byte 0 = FF, bytes 1..7 = 7F, byte 8 = 00.
- **Coalescing.** Pulse `update` 3 times mid-frame. Expect exactly one extra frame carrying the inputs sampled at its start.
- **Refresh.** Set `REFRESH_CYCLES`=1000 with no `update`. Expect frame starts spaced exactly 1000 idle cycles apart.
- **Reset mid-frame.** Assert `rst` during data byte 4. Expect outputs zero next cycle, then a complete 12-byte frame.
- **Brightness change and stall.** `brightness`=2, `disp_on`=0, with `NUM_DIGITS`=4 and `ADDR_BASE`=12. Expect C0|0C = CC and last byte 0x82. Stall `tm_busy` for 500 cycles on one byte: `tm_latch` and `tm_byte` stay stable and no byte is skipped.
